intdiv_sd2_serializer: RTL

- Accepts a WIDTH-bit two's-complement operand over a valid/ready handshake.
- Optionally negates it and recodes it into a WIDTH-digit SD2 number in (p,n) = p−n encoding.
- Emits the digits MSB-first, one per accepted beat, on a second valid/ready stream.
- It is the inverse of the SD2-to-2C converter. It feeds digit-serial (online) operands into the divider datapath. Recoding is exact: negating −2^(WIDTH−1) cannot overflow.

---
 rtl/intdiv_sd2_pkg.sv | 16 +
 rtl/intdiv_sd2_enc.sv | 17 +
 rtl/intdiv_sd2_serializer.sv | 71 +++++++
 3 files changed

// File: rtl/intdiv_sd2_pkg.sv
// Shared SD2 digit encodings and serializer state for the divider front end.
// Pure declarations: no logic, no latency, no flow control.
package intdiv_sd2_pkg;
    localparam logic [1:0] NEG1_pn   = 2'b01;
    localparam logic [1:0] ZERO_pn_1 = 2'b00;
    localparam logic [1:0] ZERO_pn_2 = 2'b11;
    localparam logic [1:0] POS1_pn   = 2'b10;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sd2_state_t;
endpackage

// File: rtl/intdiv_sd2_enc.sv
// Recodes a two's-complement word (optionally negated) into SD2 (p,n) bit-vectors.
// Combinational, zero latency, no flow control.
module intdiv_sd2_enc #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] op,
    input  logic             negate,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] n
);
    // The sign bit carries weight -2^(W-1); negation just swaps p and n,
    // so -(-2^(W-1)) is representable without any carry.
    assign p[WIDTH-1]   = negate  & op[WIDTH-1];
    assign n[WIDTH-1]   = ~negate & op[WIDTH-1];
    assign p[WIDTH-2:0] = negate ? '0 : op[WIDTH-2:0];
    assign n[WIDTH-2:0] = negate ? op[WIDTH-2:0] : '0;
endmodule

// File: rtl/intdiv_sd2_serializer.sv
// Loads a 2C operand, recodes it to SD2 and streams WIDTH digits MSB-first.
// First digit one cycle after accept; holds on dig_ready=0; back-to-back reload on the last digit.
module intdiv_sd2_serializer
    import intdiv_sd2_pkg::*;
#(
    parameter int WIDTH = 5,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_in,
    input  logic             negate,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       dig_out,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             dig_last,
    output logic [CW-1:0]    dig_pos
);
    localparam logic [CW-1:0] MSB_POS = CW'(WIDTH - 1);

    sd2_state_t       r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_n;
    logic             w_send;
    logic             w_last;
    logic             w_load;

    intdiv_sd2_enc #(.WIDTH(WIDTH)) u_enc (
        .op     (op_in),
        .negate (negate),
        .p      (w_p),
        .n      (w_n)
    );

    assign w_send = (r_state == SEND);
    assign w_last = w_send && (r_cnt == '0);
    // in_ready depends only on state and dig_ready, never on in_valid.
    assign in_ready = !w_send || (w_last && dig_ready);
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_state <= SEND;
            r_p     <= w_p;
            r_n     <= w_n;
            r_cnt   <= MSB_POS;
        end else if (w_send && dig_ready) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign dig_valid = w_send;
    assign dig_last  = w_last;
    assign dig_pos   = w_send ? r_cnt : '0;
    assign dig_out   = w_send ? {r_p[r_cnt], r_n[r_cnt]} : ZERO_pn_1;
endmodule
